// File: rtl/m_register_bank.sv
// m_register_bank: parametrised general register set with shared tri-state bus.
// Optional zero/carry flag outputs are enabled by defining MREG_BANK_FLAGS_EN.
module m_register_bank #(
  parameter int WIDTH = 8,
  parameter int REGS = 4,
  parameter int SELW = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             inCLK,
  input  logic             inReset,
  input  logic [WIDTH-1:0] inData,
  input  logic [SELW-1:0]  inWrSel,
  input  logic [2:0]       inOp,
  input  logic             inEnableOut,
  input  logic [SELW-1:0]  inRdSel,
  output logic [WIDTH-1:0] outMemory,
  output tri   [WIDTH-1:0] outData,
`ifdef MREG_BANK_FLAGS_EN
  output logic             outZero,
  output logic             outCarry,
`endif
  output logic             outBusy
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  if (REGS < 2) begin : gBadRegs
    $error("m_register_bank: REGS must be at least 2");
  end
  if ((2 ** SELW) < REGS) begin : gBadSelw
    $error("m_register_bank: SELW too narrow for REGS");
  end

  logic [WIDTH-1:0] regFile [REGS];
  logic [WIDTH-1:0] curVal;
  logic [WIDTH-1:0] nextVal;
  logic [WIDTH-1:0] rdVal;
  logic             wrValid;
  logic             opActive;
  logic             doWrite;

  logic isLoad;
  logic isInc;
  logic isDec;
  logic isShl;
  logic isShr;
  logic isClr;

  assign isLoad = (inOp == OP_LOAD);
  assign isInc  = (inOp == OP_INC);
  assign isDec  = (inOp == OP_DEC);
  assign isShl  = (inOp == OP_SHL);
  assign isShr  = (inOp == OP_SHR);
  assign isClr  = (inOp == OP_CLR);

  assign opActive = isLoad | isInc | isDec
                  | isShl | isShr | isClr;
  assign doWrite  = wrValid & opActive;

  // Select the destination register's current value; flag out-of-range selects.
  always_comb begin
    curVal  = '0;
    wrValid = 1'b0;
    for (int i = 0; i < REGS; i++) begin
      if (inWrSel == SELW'(i)) begin
        curVal  = regFile[i];
        wrValid = 1'b1;
      end
    end
  end

  // Compute the value the destination register takes for the current op.
  always_comb begin
    nextVal = curVal;
    unique case (1'b1)
      isLoad:  nextVal = inData;
      isInc:   nextVal = curVal + WIDTH'(1);
      isDec:   nextVal = curVal - WIDTH'(1);
      isShl:   nextVal = {curVal[WIDTH-2:0], 1'b0};
      isShr:   nextVal = {1'b0, curVal[WIDTH-1:1]};
      isClr:   nextVal = '0;
      default: nextVal = curVal;
    endcase
  end

  // Register file: reset all, otherwise update only the selected register.
  always_ff @(posedge inCLK) begin
    if (inReset) begin
      for (int i = 0; i < REGS; i++) begin
        regFile[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (doWrite && (inWrSel == SELW'(i))) begin
          regFile[i] <= nextVal;
        end
      end
    end
  end

  // Busy marks a bus-visible change: a real write to the register being read.
  always_ff @(posedge inCLK) begin
    if (inReset) begin
      outBusy <= 1'b0;
    end else begin
      outBusy <= doWrite && (inWrSel == inRdSel);
    end
  end

`ifdef MREG_BANK_FLAGS_EN
  logic nextCarry;

  // Carry-out of the current op, taken from the pre-update value.
  always_comb begin
    nextCarry = 1'b0;
    unique case (1'b1)
      isInc:   nextCarry = &curVal;
      isDec:   nextCarry = ~|curVal;
      isShl:   nextCarry = curVal[WIDTH-1];
      isShr:   nextCarry = curVal[0];
      default: nextCarry = 1'b0;
    endcase
  end

  // Flags follow each real write and hold otherwise.
  always_ff @(posedge inCLK) begin
    if (inReset) begin
      outZero  <= 1'b0;
      outCarry <= 1'b0;
    end else if (doWrite) begin
      outZero  <= (nextVal == '0);
      outCarry <= nextCarry;
    end
  end
`endif

  // Monitor view of the read-selected register; zero when out of range.
  always_comb begin
    rdVal = '0;
    for (int i = 0; i < REGS; i++) begin
      if (inRdSel == SELW'(i)) begin
        rdVal = regFile[i];
      end
    end
  end

  assign outMemory = rdVal;

  for (genvar b = 0; b < WIDTH; b++) begin : gBus
    assign outData[b] = inEnableOut ? rdVal[b] : 1'bz;
  end

endmodule

// File: tb/tb_m_register_bank.sv
// Randomised bench for m_register_bank: REGS=4 and REGS=3 instances
// share stimulus and are checked against an arithmetic reference model.
module tb_m_register_bank;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] INC  = 3'd2;
  localparam logic [2:0] DEC  = 3'd3;
  localparam logic [2:0] SHL  = 3'd4;
  localparam logic [2:0] SHR  = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data;
  logic [1:0] wSel;
  logic [1:0] rSel;
  logic [2:0] op;
  logic       en;

  logic [7:0] mem4;
  logic [7:0] mem3;
  wire  [7:0] bus4;
  wire  [7:0] bus3;
  logic       busy4;
  logic       busy3;
`ifdef MREG_BANK_FLAGS_EN
  logic z4, c4, z3, c3;
`endif

  for (genvar b = 0; b < 8; b++) begin : gPull
    pullup pu4 (bus4[b]);
    pullup pu3 (bus3[b]);
  end

  m_register_bank #(.WIDTH(8), .REGS(4), .SELW(2)) dut4 (
    .inCLK(clk), .inReset(rst), .inData(data),
    .inWrSel(wSel), .inOp(op), .inEnableOut(en),
    .inRdSel(rSel), .outMemory(mem4), .outData(bus4),
`ifdef MREG_BANK_FLAGS_EN
    .outZero(z4), .outCarry(c4),
`endif
    .outBusy(busy4)
  );

  m_register_bank #(.WIDTH(8), .REGS(3), .SELW(2)) dut3 (
    .inCLK(clk), .inReset(rst), .inData(data),
    .inWrSel(wSel), .inOp(op), .inEnableOut(en),
    .inRdSel(rSel), .outMemory(mem3), .outData(bus3),
`ifdef MREG_BANK_FLAGS_EN
    .outZero(z3), .outCarry(c3),
`endif
    .outBusy(busy3)
  );

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      assert (!$isunknown(op))
        else $error("inOp is X outside reset");
    end
  end

  int nChecks = 0;
  int nPass = 0;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: plain integer registers per instance.
  int  mdl [2][4];
  int  nRegs [2] = '{4, 3};
  bit  mBusy [2];
  bit  mZero [2];
  bit  mCarry [2];
  bit  modelValid = 1'b0;

  function automatic logic [7:0] expMem(int k, int s);
    if (s < nRegs[k]) return 8'(mdl[k][s]);
    return 8'h00;
  endfunction

  task automatic modelEdge();
    int w, o, old, nv, c;
    w = int'(wSel);
    o = int'(op);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) mdl[k][i] = 0;
        mBusy[k] = 0; mZero[k] = 0; mCarry[k] = 0;
      end else if (o >= 1 && o <= 6 && w < nRegs[k]) begin
        old = mdl[k][w];
        nv = old; c = 0;
        case (o)
          1: begin nv = int'(data); c = 0; end
          2: begin nv = (old + 1) % 256; c = (old == 255); end
          3: begin nv = (old + 255) % 256; c = (old == 0); end
          4: begin nv = (old * 2) % 256; c = (old >= 128); end
          5: begin nv = old / 2; c = old % 2; end
          default: begin nv = 0; c = 0; end
        endcase
        mdl[k][w] = nv;
        mZero[k] = (nv == 0);
        mCarry[k] = (c != 0);
        mBusy[k] = (w == int'(rSel));
      end else begin
        mBusy[k] = 0;
      end
    end
  endtask

  task automatic checkOut(string ph, bit post);
    int s;
    s = int'(rSel);
    chk({ph, " mem4"}, mem4, expMem(0, s));
    chk({ph, " mem3"}, mem3, expMem(1, s));
    chk({ph, " bus4"}, bus4, en ? expMem(0, s) : 8'hFF);
    chk({ph, " bus3"}, bus3, en ? expMem(1, s) : 8'hFF);
    if (post) begin
      chk({ph, " busy4"}, 8'(busy4), 8'(mBusy[0]));
      chk({ph, " busy3"}, 8'(busy3), 8'(mBusy[1]));
`ifdef MREG_BANK_FLAGS_EN
      chk({ph, " zero4"}, 8'(z4), 8'(mZero[0]));
      chk({ph, " carry4"}, 8'(c4), 8'(mCarry[0]));
      chk({ph, " zero3"}, 8'(z3), 8'(mZero[1]));
      chk({ph, " carry3"}, 8'(c3), 8'(mCarry[1]));
`endif
    end
  endtask

  task automatic cyc(bit r, logic [2:0] o, int w,
                     logic [7:0] d, int rs, bit e);
    rst = r; op = o; wSel = 2'(w);
    data = d; rSel = 2'(rs); en = e;
    #1;
    if (modelValid) checkOut("pre", 1'b0);
    @(posedge clk);
    modelEdge();
    modelValid = 1'b1;
    #1;
    checkOut("post", 1'b1);
  endtask

  task automatic sweep();
    for (int s = 0; s < 4; s++) begin
      cyc(1'b0, HOLD, $urandom_range(0, 3), 8'($urandom), s, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; op = LOAD; wSel = '0;
    data = 8'h5A; rSel = '0; en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with a LOAD pending: everything reads zero.
    cyc(1'b1, LOAD, 0, 8'h77, 0, 1'b1);
    chk("rst busy", 8'(busy4), 8'h00);
    sweep();

    // Load and bus drive / release.
    cyc(1'b0, LOAD, 2, 8'hA5, 2, 1'b1);
    chk("load bus", bus4, 8'hA5);
    cyc(1'b0, HOLD, 0, 8'h00, 2, 1'b0);
    chk("bus off mem", mem4, 8'hA5);
    chk("bus off pull", bus4, 8'hFF);
    sweep();

    // Increment wrap and decrement borrow.
    cyc(1'b0, LOAD, 1, 8'hFF, 1, 1'b1);
    cyc(1'b0, INC, 1, 8'h00, 1, 1'b1);
    chk("inc wrap", mem4, 8'h00);
    cyc(1'b0, DEC, 1, 8'h00, 1, 1'b1);
    chk("dec wrap", mem4, 8'hFF);

    // Shifts.
    cyc(1'b0, LOAD, 0, 8'h81, 0, 1'b1);
    cyc(1'b0, SHL, 0, 8'h00, 0, 1'b1);
    chk("shl", mem4, 8'h02);
    cyc(1'b0, SHR, 0, 8'h00, 0, 1'b1);
    chk("shr1", mem4, 8'h01);
    cyc(1'b0, SHR, 0, 8'h00, 0, 1'b1);
    chk("shr2", mem4, 8'h00);

    // Same-cycle read/write of reg 3 (out of range on dut3).
    cyc(1'b0, LOAD, 3, 8'h3C, 3, 1'b1);
    chk("rw new", mem4, 8'h3C);
    chk("rw busy", 8'(busy4), 8'h01);
    chk("oor mem3", mem3, 8'h00);
    chk("oor busy3", 8'(busy3), 8'h00);
    cyc(1'b0, HOLD, 3, 8'h00, 3, 1'b1);
    chk("hold busy", 8'(busy4), 8'h00);
    sweep();

    // Reset in the middle of an INC run.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, INC, i % 4, 8'h00, 0, 1'b1);
    end
    cyc(1'b1, INC, 0, 8'h00, 0, 1'b1);
    chk("rst mid inc", mem4, 8'h00);
    sweep();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      cyc($urandom_range(0, 39) == 0,
          3'($urandom_range(0, 7)),
          $urandom_range(0, 3),
          8'($urandom),
          $urandom_range(0, 3),
          $urandom_range(0, 1) == 1);
    end
    sweep();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
